// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared state type and constants for the SPI mode-0 responder.
// Imported by spi_slave and spi_slave_rx_fifo.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_slave_state_e;

    localparam int RX_FIFO_DEPTH = 4;
    localparam int SYNC_STAGES   = 2;

endpackage

// File: rtl/spi_slave_rx_fifo.sv
// spi_slave_rx_fifo: small synchronous FIFO holding received words.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module spi_slave_rx_fifo
    import spi_slave_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = RX_FIFO_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    // NOTE: storage is deliberately not reset; dout is gated by empty so stale contents never reach the port.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder (MSB first) exchanging whole frames with local logic over valid/ready.
// Define SPI_SLAVE_RX_FIFO_EN to buffer received words in a 4-entry FIFO instead of one holding register.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] IDLE_WORD = 'h00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun,
    output logic              underrun,
    output logic              abort
);
    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   ss_d;
    logic                   sclk_s;
    logic                   ss_s;
    logic                   mosi_s;
    logic                   sclk_rise_q;
    logic                   sclk_fall_q;
    logic                   ss_fall;
    logic                   ss_rise;

    spi_slave_state_e state;
    spi_slave_state_e state_nxt;

    logic [CNT_W-1:0]  bit_cnt;
    logic              frame_done;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] tx_hold;
    logic              tx_full;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] rx_word;

    logic load_tx;
    logic tx_shift_en;
    logic rx_sample;
    logic frame_end;
    logic abort_set;
    logic rx_push;
    logic rx_pop;
    logic rx_full_w;

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign ss_s    = ss_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign ss_fall = !ss_s && ss_d;
    assign ss_rise = ss_s && !ss_d;

    // sclk edges are registered once more so shift and capture land 4 cycles after the pin;
    // ss_n edges drive the FSM directly and the LOAD cycle supplies the fourth cycle there.
    // NOTE: every clocked block uses <= so all flops sample pre-edge values whatever the statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_sync   <= '0;
            ss_sync     <= '1;
            mosi_sync   <= '0;
            sclk_d      <= 1'b0;
            ss_d        <= 1'b1;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync     <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d      <= sclk_s;
            ss_d        <= ss_s;
            sclk_rise_q <= sclk_s && !sclk_d;
            sclk_fall_q <= !sclk_s && sclk_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        load_tx     = 1'b0;
        tx_shift_en = 1'b0;
        rx_sample   = 1'b0;
        frame_end   = 1'b0;
        abort_set   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) state_nxt = LOAD;
            end
            LOAD: begin
                load_tx   = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                    abort_set = (bit_cnt != '0);
                end else begin
                    if (sclk_rise_q) begin
                        rx_sample = 1'b1;
                        frame_end = (bit_cnt == LAST_BIT);
                    end
                    if (sclk_fall_q) begin
                        load_tx     = frame_done;
                        tx_shift_en = !frame_done;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign tx_ready = !tx_full;
    assign miso     = miso_oe && tx_shift[DATA_W-1];
    assign rx_word  = {rx_shift[DATA_W-2:0], mosi_s};
    assign rx_push  = frame_end;
    assign rx_pop   = rx_valid && rx_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_shift   <= '0;
            tx_hold    <= '0;
            tx_full    <= 1'b0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
            miso_oe    <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
            abort      <= 1'b0;
        end else begin
            if (load_tx)          tx_shift <= tx_full ? tx_hold : IDLE_WORD;
            else if (tx_shift_en) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};

            // Handshake needs an empty holder, so it never collides with a load that drains a full one.
            if (tx_valid && !tx_full) begin
                tx_hold <= tx_data;
                tx_full <= 1'b1;
            end else if (load_tx) begin
                tx_full <= 1'b0;
            end

            if (rx_sample) rx_shift <= rx_word;

            if (state != SHIFT || state_nxt != SHIFT || frame_end) bit_cnt <= '0;
            else if (rx_sample)                                    bit_cnt <= bit_cnt + CNT_W'(1);

            if (state_nxt != SHIFT) frame_done <= 1'b0;
            else if (frame_end)     frame_done <= 1'b1;
            else if (load_tx)       frame_done <= 1'b0;

            miso_oe  <= (state_nxt == SHIFT);
            underrun <= load_tx && !tx_full;
            overrun  <= rx_push && rx_full_w && !rx_pop;
            abort    <= abort_set;
        end
    end

`ifdef SPI_SLAVE_RX_FIFO_EN
    logic rx_empty;

    spi_slave_rx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .din   (rx_word),
        .pop   (rx_pop),
        .dout  (rx_data),
        .full  (rx_full_w),
        .empty (rx_empty)
    );

    assign rx_valid = !rx_empty;
`else
    logic              rx_full_q;
    logic [DATA_W-1:0] rx_hold;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_full_q <= 1'b0;
            rx_hold   <= '0;
        end else if (rx_push && (!rx_full_q || rx_pop)) begin
            rx_full_q <= 1'b1;
            rx_hold   <= rx_word;
        end else if (rx_pop) begin
            rx_full_q <= 1'b0;
        end
    end

    assign rx_full_w = rx_full_q;
    assign rx_valid  = rx_full_q;
    assign rx_data   = rx_hold;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed scoreboard bench for spi_slave acting as an SPI mode-0 master.
// Works with or without SPI_SLAVE_RX_FIFO_EN defined.
module tb_spi_slave;
    localparam int              DATA_W    = 8;
    localparam logic [7:0]      IDLE_WORD = 8'h00;
    localparam int              HALF      = 5;
`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int              RX_KEEP   = 4;
`else
    localparam int              RX_KEEP   = 1;
`endif

    logic              clock    = 1'b0;
    logic              reset    = 1'b1;
    logic              sclk     = 1'b0;
    logic              ss_n     = 1'b1;
    logic              mosi     = 1'b0;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data  = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready = 1'b0;
    logic              overrun;
    logic              underrun;
    logic              abort;

    int n_assert = 0;
    int n_fail   = 0;
    int n_ovr    = 0;
    int n_und    = 0;
    int n_abt    = 0;

    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];

    spi_slave #(
        .DATA_W    (DATA_W),
        .IDLE_WORD (IDLE_WORD)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .sclk     (sclk),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .overrun  (overrun),
        .underrun (underrun),
        .abort    (abort)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (overrun === 1'b1)  n_ovr++;
        if (underrun === 1'b1) n_und++;
        if (abort === 1'b1)    n_abt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},     miso,     0);
        check({tag, "_miso_oe"},  miso_oe,  0);
        check({tag, "_tx_ready"}, tx_ready, 1);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_rx_data"},  rx_data,  0);
        check({tag, "_overrun"},  overrun,  0);
        check({tag, "_underrun"}, underrun, 0);
        check({tag, "_abort"},    abort,    0);
    endtask

    task automatic queue_tx(input logic [7:0] w);
        int guard = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && guard < 200) begin
            cyc(1);
            guard++;
        end
        check("tx_ready_wait", tx_ready, 1);
        cyc(1);
        tx_valid = 1'b0;
        check("tx_ready_after_hs", tx_ready, 0);
        tx_exp.push_back(w);
    endtask

    task automatic start_frame();
        ss_n = 1'b0;
        cyc(3);
        check("oe_before_load", miso_oe, 0);
        cyc(1);
        check("oe_after_load", miso_oe, 1);
        cyc(2);
    endtask

    // One bit per 2*HALF cycles; last fall coincides with ss_n release when end_frame is set.
    task automatic spi_frame(input logic [7:0] mo, input int nbits, input bit end_frame,
                             input bit timing_chk, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            cyc(HALF);
            mi   = {mi[6:0], miso};
            sclk = 1'b1;
            if (timing_chk && i == nbits - 1) begin
                cyc(3);
                check("rx_valid_at_3", rx_valid, 0);
                cyc(1);
                check("rx_valid_at_4", rx_valid, 1);
                cyc(HALF - 4);
            end else begin
                cyc(HALF);
            end
            sclk = 1'b0;
            if (end_frame && i == nbits - 1) ss_n = 1'b1;
        end
    endtask

    task automatic full_frame(input logic [7:0] mo, input bit end_frame, input bit timing_chk,
                              input bit keep_rx);
        logic [7:0] mi;
        logic [7:0] exp_mi;
        exp_mi = (tx_exp.size() > 0) ? tx_exp.pop_front() : IDLE_WORD;
        if (keep_rx) rx_exp.push_back(mo);
        spi_frame(mo, 8, end_frame, timing_chk, mi);
        check("miso_word", mi, exp_mi);
    endtask

    task automatic pop_rx(input string tag);
        int          guard = 0;
        logic [31:0] exp;
        while (rx_valid !== 1'b1 && guard < 200) begin
            cyc(1);
            guard++;
        end
        check({tag, "_valid"}, rx_valid, 1);
        exp = (rx_exp.size() > 0) ? {24'h0, rx_exp.pop_front()} : 32'hDEAD_BEEF;
        check({tag, "_data"}, rx_data, exp);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] w;
        int         o0;
        int         u0;
        int         a0;

        // Reset state
        cyc(2);
        check_reset_outputs("por");
        reset = 1'b0;
        cyc(4);

        // Single frame
        o0 = n_ovr; u0 = n_und; a0 = n_abt;
        queue_tx(8'hA5);
        start_frame();
        full_frame(8'h3C, 1, 1, 1);
        pop_rx("single");
        cyc(6);
        check("single_overrun", n_ovr - o0, 0);
        check("single_underrun", n_und - u0, 0);
        check("single_abort", n_abt - a0, 0);
        check("single_oe_idle", miso_oe, 0);

        // Back-to-back frames under one ss_n assertion
        o0 = n_ovr; u0 = n_und;
        queue_tx(8'h11);
        start_frame();
        check("tx_ready_after_load", tx_ready, 1);
        queue_tx(8'h22);
        full_frame(8'hF0, 0, 0, 1);
        pop_rx("b2b_1");
        full_frame(8'h0F, 1, 0, 1);
        pop_rx("b2b_2");
        cyc(6);
        check("b2b_underrun", n_und - u0, 0);
        check("b2b_overrun", n_ovr - o0, 0);
        check("b2b_tx_ready", tx_ready, 1);

        // Underrun
        u0 = n_und;
        start_frame();
        full_frame(8'h96, 1, 0, 1);
        pop_rx("underrun");
        cyc(6);
        check("underrun_count", n_und - u0, 1);

        // Overrun with rx_ready held low
        o0 = n_ovr; u0 = n_und;
        for (int k = 0; k < RX_KEEP + 1; k++) begin
            w = 8'h40 + 8'(k * 17);
            start_frame();
            full_frame(w, 1, 0, k < RX_KEEP);
            cyc(6);
        end
        check("overrun_count", n_ovr - o0, 1);
        check("overrun_underruns", n_und - u0, RX_KEEP + 1);
        check("overrun_valid", rx_valid, 1);
        for (int k = 0; k < RX_KEEP; k++) pop_rx("overrun_keep");
        cyc(2);
        check("overrun_drained", rx_valid, 0);

        // Abort after 5 bits
        a0 = n_abt;
        start_frame();
        spi_frame(8'hE7, 5, 1, 0, mi);
        cyc(6);
        check("abort_count", n_abt - a0, 1);
        check("abort_no_push", rx_valid, 0);
        check("abort_oe", miso_oe, 0);
        start_frame();
        full_frame(8'h5A, 1, 0, 1);
        pop_rx("after_abort");
        cyc(6);

        // Reset mid-frame with rx and tx state populated
        start_frame();
        full_frame(8'h3A, 1, 0, 0);
        cyc(6);
        queue_tx(8'h77);
        start_frame();
        queue_tx(8'h66);
        check("pre_reset_rx_valid", rx_valid, 1);
        check("pre_reset_tx_ready", tx_ready, 0);
        spi_frame(8'h81, 3, 0, 0, mi);
        a0 = n_abt;
        reset = 1'b1;
        ss_n  = 1'b1;
        #1;
        check_reset_outputs("midframe");
        cyc(3);
        reset = 1'b0;
        tx_exp.delete();
        rx_exp.delete();
        cyc(6);
        check("reset_no_abort", n_abt - a0, 0);
        start_frame();
        full_frame(8'hC3, 1, 0, 1);
        pop_rx("after_reset");
        cyc(6);
        check("final_tx_ready", tx_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder (slave) for the simple_spi master. It operates in SPI mode 0 (CPOL=0, CPHA=0), MSB first, with a fixed frame width. The block sits on the far side of the spi_if bus as the device endpoint. It oversamples sclk, ss_n and mosi in the system clock domain and exchanges whole frames with local logic through valid/ready handshakes.

## Interface
- DATA_W, 8: frame width in bits (valid range 4..16).
- IDLE_WORD, 'h00: word shifted out on miso when no tx word is queued at frame start.
- clock  in  1  system clock; must run at ≥ 8× the sclk frequency.
- reset  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock from the master; asynchronous to clock.
- ss_n  in  1  chip select, active low; asynchronous.
- mosi  in  1  master-out data; asynchronous.
- miso  out  1  slave-out data.
- miso_oe  out  1  output enable for miso; high only while selected.
- tx_data  in  DATA_W  next word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  tx holding register is empty; a transfer occurs when tx_valid && tx_ready.
- rx_data  out  DATA_W  received word.
- rx_valid  out  1  rx_data is valid; held until popped.
- rx_ready  in  1  local logic pops the rx word when rx_valid && rx_ready.
- overrun  out  1  one-cycle pulse when a received word is dropped.
- underrun  out  1  one-cycle pulse when a frame starts with no tx word queued.
- abort  out  1  one-cycle pulse when ss_n deasserts mid-frame.

## Operation
- Input capture: sclk, ss_n and mosi each pass through a 2-flop synchronizer. Edge detection uses a third registered copy of sclk and ss_n.
- FSM states: IDLE, LOAD, SHIFT.
- IDLE
  - miso_oe=0 and miso=0.
  - On a synced falling edge of ss_n, go to LOAD.
- LOAD (one cycle)
  - If the tx holding register is full, copy it into the tx shift register and empty the holding register.
  - Otherwise load IDLE_WORD and pulse underrun.
  - Clear bit_cnt, set miso_oe=1, and drive miso with the shift-register MSB.
  - Go to SHIFT.
- SHIFT, on a synced rising edge of sclk
  - rx_shift = {rx_shift[DATA_W-2:0], mosi_sync}.
  - bit_cnt increments.
  - When bit_cnt reaches DATA_W-1 on this edge, the frame is complete: push the word to the rx path and clear bit_cnt.
- SHIFT, on a synced falling edge of sclk
  - If the frame just completed, reload the tx shift register exactly as in LOAD. This supports back-to-back frames without ss_n deassertion.
  - Otherwise shift the tx register left so miso presents the next bit.
- ss_n rising in SHIFT
  - If bit_cnt≠0, discard the partial frame and pulse abort.
  - In all cases go to IDLE; miso_oe=0 on the next cycle.
- bit_cnt is $clog2(DATA_W) bits wide and never wraps past DATA_W-1.
- tx holding register: one entry; tx_ready = !full.
- Simultaneous events
  - If a LOAD or reload and a tx handshake land in the same cycle, the load consumes the old entry and the new word enters the holding register.
  - If a push and a pop land in the same cycle on the rx path, both succeed.
- Reset (asynchronous) forces IDLE from any state, including mid-frame.
  - Outputs at reset: miso=0, miso_oe=0, tx_ready=1, rx_valid=0, rx_data=0, overrun=0, underrun=0, abort=0.
  - Shift registers and bit_cnt are cleared to 0.
  - No abort pulse is generated by reset.

## Timing
- Synchronizer latency: 2 cycles, plus 1 cycle for edge detection.
- ss_n falling edge to miso_oe=1 with first bit valid: 4 clock cycles (3 for detection, 1 for LOAD).
- The master must wait ≥ 5 clock cycles after ss_n falls before the first sclk rising edge.
- sclk falling edge to miso updated: 4 clock cycles.
- sclk high and low phases must each be ≥ 4 clock cycles.
- Last rising edge of sclk to rx_valid=1 (empty rx path): 4 clock cycles.
- tx_ready deasserts the cycle after a tx handshake and reasserts the cycle after LOAD or reload.

## Configuration
- SPI_SLAVE_RX_FIFO_EN defined:
  - The rx path is a 4-entry FIFO.
  - rx_valid = !empty.
  - overrun pulses only when a push occurs while the FIFO is full; the new word is dropped and the FIFO contents are kept.
- SPI_SLAVE_RX_FIFO_EN undefined:
  - The rx path is a single holding register.
  - A push while it is full drops the new word and pulses overrun.
- The port list is identical in both builds.

## Structure
- spi_slave_pkg holds:
  - the state enum type spi_slave_state_e (IDLE, LOAD, SHIFT);
  - the constant RX_FIFO_DEPTH=4;
  - the synchronizer stage count SYNC_STAGES=2.
- Sub-module spi_slave_rx_fifo: parameterized width and depth with push, pop, full, empty and dout. It is instantiated only under SPI_SLAVE_RX_FIFO_EN.
- Synchronizers, FSM and shift registers stay in spi_slave.

## Test plan
- Single frame: queue tx=0xA5, master sends mosi=0x3C in one frame at an sclk of 10 clock cycles per bit, then deasserts ss_n.
  - Master receives 0xA5; rx_data=0x3C with rx_valid=1 four cycles after the last rising edge; no underrun, overrun or abort.
- Back-to-back frames: queue 0x11, then queue 0x22 while frame 1 is active; master sends 0xF0 then 0x0F under one ss_n assertion.
  - miso carries 0x11 then 0x22; rx path yields 0xF0 then 0x0F.
- Underrun: no tx queued, one frame.
  - underrun pulses once; miso carries IDLE_WORD 0x00.
- Overrun: rx_ready held at 0 during the frames.
  - Without FIFO: frame 2 pulses overrun and rx_data stays at frame 1's value.
  - With FIFO: frames 1–4 are kept, frame 5 pulses overrun, and popping returns frames 1–4 in order.
- Abort: ss_n deasserts after 5 bits.
  - abort pulses; no rx push; the next full frame 0x5A is received correctly.
- Reset mid-frame: assert reset after 3 bits.
  - All outputs take their reset values immediately with miso_oe=0; after release, a full frame 0xC3 is received correctly.
